// File: rtl/accum_history.sv
// Adder-accumulator with load/add/sub/undo commands, optional unsigned clamp
// and a DEPTH-entry circular undo history.
module accum_history #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic                       add,
  input  logic                       sub,
  input  logic                       undo,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           acc_out,
  output logic                       carry,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] hist_count,
  output logic                       hist_full,
  output logic                       hist_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] hist_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    wr_ptr_n;
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    next_ptr;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic             carry_n;
  logic             overflow_n;
  logic [CW-1:0]    count_n;
  logic             push;

  // wr_ptr is the next free slot; the most recent entry sits just below it
  assign top_ptr  = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
  assign next_ptr = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

  assign sum  = {1'b0, acc_out} + {1'b0, data_in};
  assign diff = {1'b0, acc_out} - {1'b0, data_in};

  assign hist_full  = (hist_count == CW'(DEPTH));
  assign hist_empty = (hist_count == '0);

  // Command decode, priority load > add > sub > undo
  always_comb begin
    acc_n      = acc_out;
    carry_n    = carry;
    overflow_n = overflow;
    count_n    = hist_count;
    wr_ptr_n   = wr_ptr;
    push       = 1'b0;
    if (load) begin
      push       = 1'b1;
      acc_n      = data_in;
      carry_n    = 1'b0;
      overflow_n = 1'b0;
    end else if (add) begin
      push       = 1'b1;
      carry_n    = sum[WIDTH];
      overflow_n = (acc_out[WIDTH-1] == data_in[WIDTH-1]) &&
                   (sum[WIDTH-1] != acc_out[WIDTH-1]);
      acc_n      = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end else if (sub) begin
      push       = 1'b1;
      carry_n    = diff[WIDTH];
      overflow_n = (acc_out[WIDTH-1] != data_in[WIDTH-1]) &&
                   (diff[WIDTH-1] != acc_out[WIDTH-1]);
      acc_n      = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
    end else if (undo && !hist_empty) begin
      acc_n      = hist_mem[top_ptr];
      carry_n    = 1'b0;
      overflow_n = 1'b0;
      count_n    = hist_count - CW'(1);
      wr_ptr_n   = top_ptr;
    end
    // A push into a full buffer overwrites the oldest slot, which is wr_ptr
    if (push) begin
      wr_ptr_n = next_ptr;
      count_n  = hist_full ? hist_count : hist_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_out    <= '0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      hist_count <= '0;
      wr_ptr     <= '0;
    end else begin
      acc_out    <= acc_n;
      carry      <= carry_n;
      overflow   <= overflow_n;
      hist_count <= count_n;
      wr_ptr     <= wr_ptr_n;
    end
  end

  // History storage needs no reset; validity is tracked by hist_count
  always_ff @(posedge clk) begin
    if (push) hist_mem[wr_ptr] <= acc_out;
  end

endmodule

// File: tb/tb_accum_history.sv
// Bench for accum_history: wrap and saturating instances side by side,
// table vectors, a reset corner sequence and a model-driven random run.
module tb_accum_history;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0, add = 1'b0, sub = 1'b0, undo = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] acc0, acc1;
  logic         carry0, carry1, ovf0, ovf1;
  logic [2:0]   cnt0, cnt1;
  logic         full0, full1, empty0, empty1;

  accum_history #(.WIDTH(W), .DEPTH(D), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .load(load), .add(add), .sub(sub), .undo(undo),
    .data_in(data_in), .acc_out(acc0), .carry(carry0), .overflow(ovf0),
    .hist_count(cnt0), .hist_full(full0), .hist_empty(empty0));

  accum_history #(.WIDTH(W), .DEPTH(D), .SATURATE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .load(load), .add(add), .sub(sub), .undo(undo),
    .data_in(data_in), .acc_out(acc1), .carry(carry1), .overflow(ovf1),
    .hist_count(cnt1), .hist_full(full1), .hist_empty(empty1));

  always #5 clk = ~clk;

  typedef struct {
    logic l, a, s, u;
    logic [7:0] d;
    logic [7:0] acc0, acc1;
    logic c, o;
    int cnt;
  } vec_t;

  typedef struct {
    logic [7:0] acc0, acc1;
    logic c0, c1, o0, o1;
    int cnt0, cnt1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] hq [2][D];
  int         hn [2];
  logic [7:0] m_acc [2];
  logic       m_c [2];
  logic       m_o [2];

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("acc_wrap", int'(acc0), int'(e.acc0));
    check("acc_sat", int'(acc1), int'(e.acc1));
    check("carry_wrap", int'(carry0), int'(e.c0));
    check("carry_sat", int'(carry1), int'(e.c1));
    check("ovf_wrap", int'(ovf0), int'(e.o0));
    check("ovf_sat", int'(ovf1), int'(e.o1));
    check("count_wrap", int'(cnt0), e.cnt0);
    check("count_sat", int'(cnt1), e.cnt1);
    check("full_wrap", int'(full0), int'(e.cnt0 == D));
    check("empty_wrap", int'(empty0), int'(e.cnt0 == 0));
    check("full_sat", int'(full1), int'(e.cnt1 == D));
    check("empty_sat", int'(empty1), int'(e.cnt1 == 0));
  endtask

  task automatic apply(input logic l, a, s, u, input logic [7:0] d, input exp_t e);
    @(negedge clk);
    load = l; add = a; sub = s; undo = u; data_in = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic model_push(input int v, input logic [7:0] val);
    if (hn[v] == D) begin
      for (int i = 0; i < D - 1; i++) hq[v][i] = hq[v][i+1];
      hn[v] = D - 1;
    end
    hq[v][hn[v]] = val;
    hn[v]++;
  endtask

  task automatic model_one(input int v, input bit sat, input logic l, a, s, u,
                           input logic [7:0] d);
    logic [7:0] pre;
    logic [7:0] rr;
    int r;
    pre = m_acc[v];
    if (l) begin
      model_push(v, pre);
      m_acc[v] = d; m_c[v] = 1'b0; m_o[v] = 1'b0;
    end else if (a) begin
      r = int'(pre) + int'(d);
      rr = 8'(r);
      m_c[v] = (r > 255);
      m_o[v] = (pre[7] == d[7]) && (rr[7] != pre[7]);
      m_acc[v] = (sat && m_c[v]) ? 8'hFF : rr;
      model_push(v, pre);
    end else if (s) begin
      rr = pre - d;
      m_c[v] = (d > pre);
      m_o[v] = (pre[7] != d[7]) && (rr[7] != pre[7]);
      m_acc[v] = (sat && m_c[v]) ? 8'h00 : rr;
      model_push(v, pre);
    end else if (u && hn[v] > 0) begin
      hn[v]--;
      m_acc[v] = hq[v][hn[v]];
      m_c[v] = 1'b0; m_o[v] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      hn[v] = 0; m_acc[v] = 8'h00; m_c[v] = 1'b0; m_o[v] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic l, a, s, u, input logic [7:0] d);
    exp_t e;
    model_one(0, 1'b0, l, a, s, u, d);
    model_one(1, 1'b1, l, a, s, u, d);
    e = '{acc0: m_acc[0], acc1: m_acc[1], c0: m_c[0], c1: m_c[1],
          o0: m_o[0], o1: m_o[1], cnt0: hn[0], cnt1: hn[1]};
    apply(l, a, s, u, d, e);
  endtask

  initial begin
    exp_t e;
    // l a s u  data   wrap   sat    c o cnt
    tbl.push_back(vec_t'{1,0,0,0, 8'h10, 8'h10, 8'h10, 0,0, 1});
    tbl.push_back(vec_t'{0,1,0,0, 8'h05, 8'h15, 8'h15, 0,0, 2});
    tbl.push_back(vec_t'{1,0,0,0, 8'hF0, 8'hF0, 8'hF0, 0,0, 3});
    tbl.push_back(vec_t'{0,1,0,0, 8'h20, 8'h10, 8'hFF, 1,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h7F, 8'h7F, 8'h7F, 0,0, 4});
    tbl.push_back(vec_t'{0,1,0,0, 8'h01, 8'h80, 8'h80, 0,1, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h00, 8'h00, 8'h00, 0,0, 4});
    tbl.push_back(vec_t'{0,0,1,0, 8'h01, 8'hFF, 8'h00, 1,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h01, 8'h01, 8'h01, 0,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h02, 8'h02, 8'h02, 0,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h03, 8'h03, 8'h03, 0,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h04, 8'h04, 8'h04, 0,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h05, 8'h05, 8'h05, 0,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h06, 8'h06, 8'h06, 0,0, 4});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h05, 8'h05, 0,0, 3});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h04, 8'h04, 0,0, 2});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h03, 8'h03, 0,0, 1});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h02, 8'h02, 0,0, 0});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h02, 8'h02, 0,0, 0});
    tbl.push_back(vec_t'{1,0,0,0, 8'hFF, 8'hFF, 8'hFF, 0,0, 1});
    tbl.push_back(vec_t'{0,1,0,0, 8'h02, 8'h01, 8'hFF, 1,0, 2});
    tbl.push_back(vec_t'{1,1,0,0, 8'h33, 8'h33, 8'h33, 0,0, 3});
    tbl.push_back(vec_t'{0,1,1,1, 8'h10, 8'h43, 8'h43, 0,0, 4});
    tbl.push_back(vec_t'{0,0,1,1, 8'h50, 8'hF3, 8'h00, 1,0, 4});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h43, 8'h43, 0,0, 3});
    tbl.push_back(vec_t'{0,0,1,0, 8'h01, 8'h42, 8'h42, 0,0, 4});
    tbl.push_back(vec_t'{1,0,0,0, 8'h80, 8'h80, 8'h80, 0,0, 4});
    tbl.push_back(vec_t'{0,0,1,0, 8'h01, 8'h7F, 8'h7F, 0,1, 4});
    tbl.push_back(vec_t'{0,1,0,0, 8'h00, 8'h7F, 8'h7F, 0,0, 4});
    tbl.push_back(vec_t'{0,0,0,1, 8'h00, 8'h7F, 8'h7F, 0,0, 3});
    tbl.push_back(vec_t'{1,0,0,0, 8'hAA, 8'hAA, 8'hAA, 0,0, 4});
    tbl.push_back(vec_t'{0,1,0,0, 8'h01, 8'hAB, 8'hAB, 0,0, 4});

    // Reset state
    #12;
    check("rst_acc", int'(acc0), 0);
    check("rst_count", int'(cnt0), 0);
    check("rst_empty", int'(empty0), 1);
    check("rst_full", int'(full1), 0);
    check("rst_flags", int'({carry0, ovf0, carry1, ovf1}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      e = '{acc0: tbl[i].acc0, acc1: tbl[i].acc1, c0: tbl[i].c, c1: tbl[i].c,
            o0: tbl[i].o, o1: tbl[i].o, cnt0: tbl[i].cnt, cnt1: tbl[i].cnt};
      apply(tbl[i].l, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].d, e);
    end

    // Asynchronous reset between edges, then held across an edge with load high
    @(negedge clk);
    load = 1'b1; add = 1'b0; sub = 1'b0; undo = 1'b0; data_in = 8'h5A;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_acc", int'(acc0), 0);
    check("async_rst_acc_sat", int'(acc1), 0);
    check("async_rst_count", int'(cnt0), 0);
    check("async_rst_empty", int'(empty0), 1);
    @(posedge clk);
    #1;
    check("rst_hold_acc", int'(acc0), 0);
    check("rst_hold_count", int'(cnt1), 0);
    @(negedge clk);
    load = 1'b0;
    reset_n = 1'b1;

    // Random commands against the reference model
    model_reset();
    model_apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      case ($urandom_range(0, 5))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'h80;
        default: d = 8'($urandom_range(0, 255));
      endcase
      model_apply($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, d);
    end

    @(negedge clk);
    load = 1'b0; add = 1'b0; sub = 1'b0; undo = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_history.md
# accum_history

Parametrised adder-accumulator with a load/add/subtract/undo command set, optional unsigned saturation and a DEPTH-entry undo history. It sits between the button edge-to-pulse stage and the 7-segment/LED display path on the board top level. The front-end supplies single-cycle command pulses and a WIDTH-bit operand from the switches. The registered accumulator value and status flags go to the display.

## Interface
- WIDTH, 8, operand and accumulator width in bits (2..32)
- DEPTH, 4, undo history entries (1..16)
- SATURATE, 0, 0 = modular wrap; 1 = unsigned clamp on add/sub
- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  single-cycle pulse: acc <= data_in
- add  in  1  single-cycle pulse: acc <= acc + data_in
- sub  in  1  single-cycle pulse: acc <= acc - data_in
- undo  in  1  single-cycle pulse: acc <= most recent history entry
- data_in  in  WIDTH  operand, sampled on the command edge
- acc_out  out  WIDTH  registered accumulator value
- carry  out  1  unsigned carry (add) or borrow (sub) of the last arithmetic op
- overflow  out  1  two's-complement overflow of the last arithmetic op
- hist_count  out  $clog2(DEPTH+1)  number of valid history entries
- hist_full  out  1  hist_count == DEPTH
- hist_empty  out  1  hist_count == 0

## Operation
- Reset (reset_n low, asynchronous):
  - acc_out, carry, overflow and hist_count go to 0.
  - hist_empty = 1, hist_full = 0.
  - History storage contents are don't-care.
- Command priority when pulses coincide: load > add > sub > undo. Exactly one command executes per cycle; the others are dropped.
- Mutating commands (load, add, sub):
  - Push the pre-op acc value onto the history LIFO.
  - When the LIFO is full, the oldest entry is discarded; hist_count stays at DEPTH.
  - The history is a circular buffer with a top pointer, so no shifting is used.
- undo:
  - hist_empty = 0: pop the top entry into acc; hist_count decrements.
  - hist_empty = 1: no-op. acc, flags and count are unchanged.
- Arithmetic is computed at WIDTH+1 bits.
  - add: carry = bit WIDTH of the sum.
  - sub: carry = 1 when data_in > acc (unsigned borrow).
  - overflow follows the standard signed rule on the operand and result MSBs.
- SATURATE=1:
  - add with carry: acc <= all-ones.
  - sub with borrow: acc <= 0.
  - carry and overflow still report the unclamped result.
- SATURATE=0: acc takes the low WIDTH bits of the result.
- load and undo clear carry and overflow. The flags hold their value until the next command.
- Arithmetic on an unchanged result (e.g. add 0) still pushes history.

## Timing
- All outputs are registered. A command pulse sampled at edge N is reflected on acc_out, flags and hist_* after edge N.
- Latency is 1 cycle and throughput is 1 command per cycle. Back-to-back pulses on consecutive cycles all execute.
- A command issued in the cycle after another operates on the updated acc. No bypass hazard exists because acc is the register itself.
- A command held high for k cycles executes k times. Pulse shaping belongs to the front-end.
- Reset asserted mid-command wins immediately; the pending command is lost. On reset deassertion the first edge may execute a command sampled at that edge.
- hist_full and hist_empty are decoded from the registered count and change on the same edge as hist_count.

## Test plan
1. Reset, then load 0x10, add 0x05 -> acc_out 0x10 then 0x15; carry 0, overflow 0, hist_count 2.
2. Load 0xF0, add 0x20 with SATURATE=0 -> acc 0x10, carry 1. Same sequence with SATURATE=1 -> acc 0xFF, carry 1.
3. Load 0x7F, add 0x01 -> acc 0x80, overflow 1, carry 0. Then load 0x00, sub 0x01 -> acc 0xFF (SATURATE=0) or 0x00 (SATURATE=1), carry 1.
4. With DEPTH=4: load 1, 2, 3, 4, 5, 6 -> hist_count saturates at 4, hist_full 1.
   - Four undos yield acc 5, 4, 3, 2; hist_empty 1.
   - A fifth undo leaves acc 2.
5. Assert load and add in the same cycle with data_in 0x33 and acc 0x01 -> acc 0x33 (load wins), hist_count +1, flags 0.
6. Load 0xAA, add 0x01, then pull reset_n low between edges -> acc_out and hist_count read 0 immediately, before the next clk edge.
